control_unit: RTL
=================

# control_unit

Multi-cycle RV32I control FSM that sequences the shared core datapath: register file, ALU, PC/IR/MDR/ALUOut registers, unified memory port and immediate generator. It decodes the 7-bit opcode latched in IR and drives all write enables and mux selects, one micro-step per clock. Memory accesses stall on a ready handshake.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous reset, active low
- instr_opcode_i  in  7  IR[6:0], valid from DECODE onward
- mem_ready_i  in  1  memory completes current access this cycle
- pc_write_o  out  1  unconditional PC load
- pc_write_cond_o  out  1  PC load if ALU zero/compare true
- ir_write_o  out  1  IR and old_pc load
- lord_o  out  1  memory address: 0 = PC, 1 = ALUOut
- mem_read_o / mem_write_o  out  1 each  memory request
- reg_write_o  out  1  register-file write
- mem_to_reg_o  out  2  00 ALUOut, 01 MDR, 10 PC
- alu_src_a_o  out  2  00 PC, 01 rs1, 10 old_pc, 11 zero
- alu_src_b_o  out  2  00 rs2, 01 const 4, 10 immediate
- alu_op_o  out  2  00 add, 01 branch compare, 10 funct3/funct7 decode
- pc_source_o  out  1  0 ALU result, 1 ALUOut
- illegal_instr_o  out  1  one-cycle pulse, unsupported opcode

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC_R, EXEC_I, ALU_WB, BRANCH, JAL, JALR, LUI, AUIPC.
- Any output not listed for a state is 0.
- FETCH: mem_read=1, lord=0, a=00, b=01, op=00.
  - ir_write = pc_write = mem_ready_i.
  - Stay while mem_ready_i=0; else go to DECODE.
- DECODE: a=10, b=10, op=00, so ALUOut = old_pc + imm (branch/JAL target). Dispatch on opcode:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 → LUI
  - 0010111 → AUIPC
  - other → illegal_instr=1, then FETCH
- MEMADR: a=01, b=10, op=00. Go to MEMREAD if load, MEMWRITE if store.
- MEMREAD: mem_read=1, lord=1. Wait for mem_ready_i, then MEMWB.
- MEMWB: reg_write=1, mem_to_reg=01. Then FETCH.
- MEMWRITE: mem_write=1, lord=1. Wait for mem_ready_i, then FETCH.
- EXEC_R: a=01, b=00, op=10. Then ALU_WB.
- EXEC_I: a=01, b=10, op=10. Then ALU_WB.
- LUI: a=11, b=10, op=00. Then ALU_WB.
- AUIPC: a=10, b=10, op=00. Then ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=00. Then FETCH.
- BRANCH: a=01, b=00, op=01, pc_write_cond=1, pc_source=1. Then FETCH.
- JAL: pc_write=1, pc_source=1, reg_write=1, mem_to_reg=10. Then FETCH.
  - rd receives the already-incremented PC.
- JALR: a=01, b=10, op=00, pc_write=1, pc_source=0, reg_write=1, mem_to_reg=10. Then FETCH.
- Memory requests stay asserted, with constant selects, until mem_ready_i is seen high.

## Timing
- Outputs are combinational from the state register. Only FETCH ir_write and pc_write also depend on mem_ready_i.
- rst_n low: state forced to FETCH asynchronously and all outputs forced to 0.
- First FETCH request is asserted in the first cycle with rst_n high.
- Reset mid-instruction abandons the instruction, with no further writes.
- Cycles per instruction at zero wait (mem_ready_i=1 whenever requested):
  - load 5
  - store, R-type, I-ALU, LUI, AUIPC: 4
  - branch, JAL, JALR: 3
- Each wait cycle adds one cycle in FETCH, MEMREAD or MEMWRITE.
- mem_ready_i outside a request state is ignored.
- The opcode is sampled only in DECODE and MEMADR; IR does not change until the next FETCH.

## Structure
- Shared package riscv_pkg holds:
  - opcode constants, also used by the immediate generator
  - state enum
  - encodings for alu_src_a, alu_src_b, alu_op and mem_to_reg
- Single module with a registered state and combinational next-state and output logic. No sub-module.

## Test plan
- Reset, then release with mem_ready_i=1 → cycle 0 in FETCH with mem_read=1, ir_write=1, pc_write=1; rst_n low forces all outputs 0.
- Opcode 0000011, mem_ready_i low for 2 cycles in MEMREAD → state sequence F,D,MA,MR,MR,MR,MWB with lord=1 throughout MEMREAD; reg_write with mem_to_reg=01 in the 7th cycle.
- Opcode 0100011, zero wait → F,D,MA,MW; mem_write=1 exactly one cycle; reg_write never asserted.
- Opcode 1100011 → BRANCH asserts pc_write_cond=1, pc_source=1, alu_op=01, with pc_write=0.
- Opcode 1101111 then 1100111 → JAL: pc_source=1, mem_to_reg=10; JALR: a=01, b=10, pc_source=0; each takes 3 cycles.
- Opcode 1111111 → illegal_instr pulses 1 cycle in DECODE, then FETCH; rst_n asserted mid-MEMREAD → immediately FETCH, outputs 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcode constants, control FSM states and the
// encodings of the datapath mux selects driven by the control unit.
package riscv_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXEC_R, S_EXEC_I, S_ALU_WB, S_BRANCH, S_JAL, S_JALR, S_LUI, S_AUIPC
  } cu_state_e;

  typedef enum logic [1:0] {
    SRCA_PC = 2'b00, SRCA_RS1 = 2'b01, SRCA_OLDPC = 2'b10, SRCA_ZERO = 2'b11
  } alu_src_a_e;

  typedef enum logic [1:0] {
    SRCB_RS2 = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10
  } alu_src_b_e;

  typedef enum logic [1:0] {
    ALUOP_ADD = 2'b00, ALUOP_BRANCH = 2'b01, ALUOP_FUNCT = 2'b10
  } alu_op_e;

  typedef enum logic [1:0] {
    M2R_ALUOUT = 2'b00, M2R_MDR = 2'b01, M2R_PC = 2'b10
  } mem_to_reg_e;

endpackage

// File: rtl/control_unit.sv
// Multi-cycle RV32I control FSM: one micro-step per clock, decoding the
// opcode held in IR and driving every datapath enable and mux select.
module control_unit
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] instr_opcode_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       pc_write_cond_o,
  output logic       ir_write_o,
  output logic       lord_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       reg_write_o,
  output logic [1:0] mem_to_reg_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic       pc_source_o,
  output logic       illegal_instr_o
);

  cu_state_e state_q, state_d;

  // State register; reset abandons any instruction and restarts at FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state logic: memory states hold until the ready handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready_i) state_d = S_DECODE;
      S_DECODE: begin
        case (instr_opcode_i)
          OPC_LOAD, OPC_STORE: state_d = S_MEMADR;
          OPC_OP:              state_d = S_EXEC_R;
          OPC_OP_IMM:          state_d = S_EXEC_I;
          OPC_BRANCH:          state_d = S_BRANCH;
          OPC_JAL:             state_d = S_JAL;
          OPC_JALR:            state_d = S_JALR;
          OPC_LUI:             state_d = S_LUI;
          OPC_AUIPC:           state_d = S_AUIPC;
          default:             state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (instr_opcode_i == OPC_LOAD)       state_d = S_MEMREAD;
        else if (instr_opcode_i == OPC_STORE) state_d = S_MEMWRITE;
        else                                  state_d = S_FETCH;
      end
      S_MEMREAD:  if (mem_ready_i) state_d = S_MEMWB;
      S_MEMWRITE: if (mem_ready_i) state_d = S_FETCH;
      S_EXEC_R, S_EXEC_I, S_LUI, S_AUIPC: state_d = S_ALU_WB;
      S_MEMWB, S_ALU_WB, S_BRANCH, S_JAL, S_JALR: state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // Output decode from the current state; everything is held low in reset.
  always_comb begin
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    ir_write_o      = 1'b0;
    lord_o          = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    reg_write_o     = 1'b0;
    mem_to_reg_o    = M2R_ALUOUT;
    alu_src_a_o     = SRCA_PC;
    alu_src_b_o     = SRCB_RS2;
    alu_op_o        = ALUOP_ADD;
    pc_source_o     = 1'b0;
    illegal_instr_o = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = SRCB_FOUR;
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
      end
      S_DECODE: begin
        alu_src_a_o = SRCA_OLDPC;
        alu_src_b_o = SRCB_IMM;
        case (instr_opcode_i)
          OPC_LOAD, OPC_STORE, OPC_OP, OPC_OP_IMM, OPC_BRANCH,
          OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: illegal_instr_o = 1'b0;
          default:                               illegal_instr_o = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alu_src_a_o = SRCA_RS1;
        alu_src_b_o = SRCB_IMM;
      end
      S_MEMREAD: begin
        mem_read_o = 1'b1;
        lord_o     = 1'b1;
      end
      S_MEMWB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = M2R_MDR;
      end
      S_MEMWRITE: begin
        mem_write_o = 1'b1;
        lord_o      = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a_o = SRCA_RS1;
        alu_op_o    = ALUOP_FUNCT;
      end
      S_EXEC_I: begin
        alu_src_a_o = SRCA_RS1;
        alu_src_b_o = SRCB_IMM;
        alu_op_o    = ALUOP_FUNCT;
      end
      S_LUI: begin
        alu_src_a_o = SRCA_ZERO;
        alu_src_b_o = SRCB_IMM;
      end
      S_AUIPC: begin
        alu_src_a_o = SRCA_OLDPC;
        alu_src_b_o = SRCB_IMM;
      end
      S_ALU_WB: reg_write_o = 1'b1;
      S_BRANCH: begin
        alu_src_a_o     = SRCA_RS1;
        alu_op_o        = ALUOP_BRANCH;
        pc_write_cond_o = 1'b1;
        pc_source_o     = 1'b1;
      end
      S_JAL: begin
        pc_write_o   = 1'b1;
        pc_source_o  = 1'b1;
        reg_write_o  = 1'b1;
        mem_to_reg_o = M2R_PC;
      end
      S_JALR: begin
        alu_src_a_o  = SRCA_RS1;
        alu_src_b_o  = SRCB_IMM;
        pc_write_o   = 1'b1;
        reg_write_o  = 1'b1;
        mem_to_reg_o = M2R_PC;
      end
      default: ;
    endcase
    if (!rst_n) begin
      pc_write_o      = 1'b0;
      ir_write_o      = 1'b0;
      mem_read_o      = 1'b0;
      alu_src_a_o     = SRCA_PC;
      alu_src_b_o     = SRCB_RS2;
      pc_write_cond_o = 1'b0;
      lord_o          = 1'b0;
      mem_write_o     = 1'b0;
      reg_write_o     = 1'b0;
      mem_to_reg_o    = M2R_ALUOUT;
      alu_op_o        = ALUOP_ADD;
      pc_source_o     = 1'b0;
      illegal_instr_o = 1'b0;
    end
  end

endmodule
